// File: rtl/lighting_pkg.sv
// rtl/lighting_pkg.sv - shared FSM state type, time-code default and lamp thermometer decode.
package lighting_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_RAMP
  } state_t;

  localparam int TCODE_MAX_DEF = 11;

  // First time code treated as night by the automatic lighting mode.
  localparam logic [3:0] NIGHT_TCODE = 4'd6;

  function automatic logic [15:0] therm16(input logic [3:0] n);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

endpackage

// File: rtl/lamp_ramp.sv
// rtl/lamp_ramp.sv - step timer plus +/-1 walk of one 4-bit level toward its target.
module lamp_ramp #(
  parameter int STEP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       force_en,
  input  logic [3:0] force_val,
  input  logic [3:0] target,
  output logic [3:0] value,
  output logic       at_target
);

  logic [7:0] cnt;
  logic       step;

  // Dropping run clears the timer, so every ramp entry waits a full STEP_CYC.
  assign step      = run && (cnt == 8'(STEP_CYC - 1));
  assign at_target = (value == target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      value <= '0;
    end else begin
      if (!run || step) cnt <= '0;
      else              cnt <= cnt + 8'd1;

      if (force_en)                     value <= force_val;
      else if (step && value < target)  value <= value + 4'd1;
      else if (step && value > target)  value <= value - 4'd1;
    end
  end

endmodule

// File: rtl/lighting_ctrl.sv
// rtl/lighting_ctrl.sv - room lighting sequencer: time code, request latch, eval/ramp FSM.
// Optional LIGHTING_CTRL_OVERRIDE_EN adds an ovr input that forces full light.
module lighting_ctrl
  import lighting_pkg::*;
#(
  parameter int STEP_CYC       = 4,
  parameter int TICKS_PER_CODE = 8,
  parameter int TCODE_MAX      = TCODE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        ureq_valid,
  input  logic [3:0]  ureq_mode,
  output logic        ureq_ready,
  input  logic [3:0]  length,
`ifdef LIGHTING_CTRL_OVERRIDE_EN
  input  logic        ovr,
`endif
  output logic [3:0]  tcode,
  output logic [3:0]  lightnum,
  output logic [15:0] lightstate,
  output logic [3:0]  wshade,
  output logic        busy,
  output logic        done
);

  state_t     state, state_next;
  logic [7:0] tick_cnt;
  logic [3:0] umode;
  logic       pending_eval;
  logic [3:0] tgt_num, tgt_shade;
  logic [3:0] dp_num, dp_shade;
  logic       req_acc, code_evt, num_at, shade_at, ramp_run, done_next;
  logic       ovr_on, ovr_fall;

`ifdef LIGHTING_CTRL_OVERRIDE_EN
  logic ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= ovr;
  end

  assign ovr_on   = ovr;
  assign ovr_fall = ovr_q && !ovr;
`else
  assign ovr_on   = 1'b0;
  assign ovr_fall = 1'b0;
`endif

  assign ureq_ready = (state != ST_EVAL);
  assign req_acc    = ureq_valid && ureq_ready;
  assign code_evt   = tick && (tick_cnt == 8'(TICKS_PER_CODE - 1));
  assign busy       = (state != ST_IDLE);
  assign lightstate = therm16(lightnum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      tcode    <= '0;
    end else if (tick) begin
      if (code_evt) begin
        tick_cnt <= '0;
        tcode    <= (tcode == 4'(TCODE_MAX)) ? 4'd0 : tcode + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + 8'd1;
      end
    end
  end

  // A new event outranks the clear, so a tick landing in EVAL is re-evaluated later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      umode        <= '0;
      pending_eval <= 1'b0;
    end else begin
      if (req_acc) umode <= ureq_mode;
      if (req_acc || code_evt)  pending_eval <= 1'b1;
      else if (state == ST_EVAL) pending_eval <= 1'b0;
    end
  end

  // Mode 0 follows the clock and room size; other modes ask for 3 lamps per step.
  always_comb begin
    dp_num   = '0;
    dp_shade = '0;
    if (umode == 4'd0) begin
      if (tcode >= NIGHT_TCODE) begin
        dp_num   = length;
        dp_shade = 4'd0;
      end else begin
        dp_num   = {1'b0, length[3:1]};
        dp_shade = {1'b0, length[3:1]};
      end
    end else begin
      dp_num   = (umode > 4'd5) ? 4'd15 : umode + (umode << 1);
      dp_shade = {1'b0, umode[3:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_num   <= '0;
      tgt_shade <= '0;
    end else if (state == ST_EVAL) begin
      tgt_num   <= dp_num;
      tgt_shade <= dp_shade;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: if (req_acc || code_evt || pending_eval) state_next = ST_EVAL;
      ST_EVAL: begin
        if (dp_num == lightnum && dp_shade == wshade) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (req_acc) begin
          state_next = ST_EVAL;
        end else if (num_at && shade_at) begin
          done_next  = 1'b1;
          state_next = pending_eval ? ST_EVAL : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (ovr_on) begin
      state_next = ST_IDLE;
      done_next  = 1'b0;
    end else if (ovr_fall) begin
      state_next = ST_EVAL;
    end
  end

  // A request accepted mid-ramp freezes stepping so the reload starts a fresh step period.
  assign ramp_run = (state == ST_RAMP) && !req_acc && !ovr_on;

  lamp_ramp #(.STEP_CYC(STEP_CYC)) u_num_ramp (
    .clk       (clk),
    .rst       (rst),
    .run       (ramp_run),
    .force_en  (ovr_on),
    .force_val (4'd15),
    .target    (tgt_num),
    .value     (lightnum),
    .at_target (num_at)
  );

  lamp_ramp #(.STEP_CYC(STEP_CYC)) u_shade_ramp (
    .clk       (clk),
    .rst       (rst),
    .run       (ramp_run),
    .force_en  (ovr_on),
    .force_val (4'd0),
    .target    (tgt_shade),
    .value     (wshade),
    .at_target (shade_at)
  );

endmodule

// File: tb/tb_lighting_ctrl.sv
// tb/tb_lighting_ctrl.sv - scoreboard bench for lighting_ctrl against a rule-level reference model.
module tb_lighting_ctrl;

  localparam int STEP = 4;
  localparam int TPC  = 8;
  localparam int TMAX = 11;

  logic        clk = 1'b0;
  logic        rst, tick, ureq_valid;
  logic [3:0]  ureq_mode, length;
  logic        ureq_ready, busy, done;
  logic [3:0]  tcode, lightnum, wshade;
  logic [15:0] lightstate;
`ifdef LIGHTING_CTRL_OVERRIDE_EN
  logic        ovr = 1'b0;
`endif

  always #5 clk = ~clk;

  lighting_ctrl #(.STEP_CYC(STEP), .TICKS_PER_CODE(TPC), .TCODE_MAX(TMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .ureq_valid (ureq_valid),
    .ureq_mode  (ureq_mode),
    .ureq_ready (ureq_ready),
    .length     (length),
`ifdef LIGHTING_CTRL_OVERRIDE_EN
    .ovr        (ovr),
`endif
    .tcode      (tcode),
    .lightnum   (lightnum),
    .lightstate (lightstate),
    .wshade     (wshade),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int num;
    int shade;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   m_num, m_shade, m_tc, m_tick, m_umode;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_num(input int m, input int len, input int tc);
    if (m == 0) return (tc >= 6) ? len : len / 2;
    return (m * 3 > 15) ? 15 : m * 3;
  endfunction

  function automatic int ref_shade(input int m, input int len, input int tc);
    if (m == 0) return (tc >= 6) ? 0 : len / 2;
    return m / 2;
  endfunction

  // Ramp time: one EVAL cycle, then STEP cycles per unit of the larger distance, then the exit cycle.
  function automatic int ref_latency(input int dn, input int ds);
    int a, b, s;
    a = (dn < 0) ? -dn : dn;
    b = (ds < 0) ? -ds : ds;
    s = (a > b) ? a : b;
    return (s == 0) ? 1 : STEP * s + 2;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("done_lightnum", int'(lightnum), mon_e.num);
        check("done_wshade", int'(wshade), mon_e.shade);
        check("done_cycle", cyc, mon_e.at);
        check("done_lightstate", int'(lightstate), (1 << mon_e.num) - 1);
      end
    end
  end

  task automatic model_reset();
    m_num = 0; m_shade = 0; m_tc = 0; m_tick = 0; m_umode = 0;
  endtask

  // Called at a negedge; drives one cycle of tick and/or request and predicts any resulting EVAL.
  task automatic stim(input bit do_tick, input bit do_req, input int mode, input bit push_en);
    bit evt;
    int tn, ts;
    if (do_req) check("ready_before_req", int'(ureq_ready), 1);
    tick       = do_tick;
    ureq_valid = do_req;
    ureq_mode  = 4'(mode);
    @(posedge clk);
    #1;
    tick       = 1'b0;
    ureq_valid = 1'b0;
    evt        = do_req;
    if (do_req) m_umode = mode;
    if (do_tick) begin
      m_tick++;
      if (m_tick == TPC) begin
        m_tick = 0;
        m_tc   = (m_tc == TMAX) ? 0 : m_tc + 1;
        evt    = 1'b1;
      end
    end
    check("tcode", int'(tcode), m_tc);
    if (evt) begin
      check("busy_after_event", int'(busy), 1);
      tn = ref_num(m_umode, int'(length), m_tc);
      ts = ref_shade(m_umode, int'(length), m_tc);
      if (push_en) sb.push_back('{tn, ts, cyc + ref_latency(tn - m_num, ts - m_shade)});
      m_num   = tn;
      m_shade = ts;
    end
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", int'(n < budget), 1);
  endtask

  task automatic wait_lightnum(input int v, input int budget);
    int n;
    n = 0;
    while (int'(lightnum) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("reach_lightnum", int'(lightnum), v);
  endtask

  task automatic tick_group();
    for (int i = 0; i < TPC; i++) begin
      stim(1'b1, 1'b0, 0, 1'b1);
      @(negedge clk);
    end
    wait_drain(200);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int prev, changes;
    rst = 1'b1; tick = 1'b0; ureq_valid = 1'b0; ureq_mode = '0; length = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_lightnum", int'(lightnum), 0);
    check("rst_lightstate", int'(lightstate), 0);
    check("rst_wshade", int'(wshade), 0);
    check("rst_tcode", int'(tcode), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(ureq_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // Mode 3 from dark: target 9, 36 ramp cycles before the last step.
    length = 4'd10;
    stim(1'b0, 1'b1, 3, 1'b1);
    wait_drain(200);

    for (int it = 0; it < 12; it++) begin
      length = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) tick_group();
      else begin
        stim(1'b0, 1'b1, int'($urandom_range(0, 15)), 1'b1);
        wait_drain(200);
      end
    end

    // Walk the time code to its last value, then one more group must wrap it.
    while (m_tc != TMAX) tick_group();
    tick_group();
    check("tcode_wrap", int'(tcode), 0);

    // Tick and request together: one EVAL, umode taken from the request.
    for (int i = 0; i < TPC - 1; i++) begin
      stim(1'b1, 1'b0, 0, 1'b1);
      @(negedge clk);
    end
    length = 4'd7;
    stim(1'b1, 1'b1, (m_umode == 5) ? 2 : 5, 1'b1);
    wait_drain(200);

    // Retarget mid-ramp: from 6 the lamps must walk down one at a time to 2.
    length = 4'd0;
    stim(1'b0, 1'b1, 0, 1'b1);
    wait_drain(200);
    stim(1'b0, 1'b1, 4, 1'b0);
    wait_lightnum(6, 100);
    m_num = 6; m_shade = 2;
    length = (m_tc >= 6) ? 4'd2 : 4'd4;
    stim(1'b0, 1'b1, 0, 1'b1);
    prev = 6; changes = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      if (int'(lightnum) != prev) begin
        check("step_down", int'(lightnum), prev - 1);
        prev = int'(lightnum);
        changes++;
      end
      @(negedge clk);
    end
    check("step_count", changes, 4);
    wait_drain(100);

    // Reset in the middle of a ramp abandons it silently.
    stim(1'b0, 1'b1, 3, 1'b0);
    wait_lightnum(5, 100);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_lightnum", int'(lightnum), 0);
    check("midrst_lightstate", int'(lightstate), 0);
    check("midrst_wshade", int'(wshade), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_tcode", int'(tcode), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (60) @(negedge clk);
    check("post_rst_lightnum", int'(lightnum), 0);
    check("post_rst_busy", int'(busy), 0);

`ifdef LIGHTING_CTRL_OVERRIDE_EN
    stim(1'b0, 1'b1, 3, 1'b0);
    repeat (10) @(negedge clk);
    ovr = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_lightnum", int'(lightnum), 15);
    check("ovr_wshade", int'(wshade), 0);
    repeat (3) @(negedge clk);
    check("ovr_busy", int'(busy), 0);
    ovr = 1'b0;
    @(posedge clk);
    #1;
    check("ovr_fall_busy", int'(busy), 1);
    sb.push_back('{9, 1, cyc + ref_latency(9 - 15, 1 - 0)});
    m_num = 9; m_shade = 1;
    @(negedge clk);
    wait_drain(200);
`endif

    repeat (5) @(negedge clk);
    check("sb_empty_at_end", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
